ctr_uart_tx: RTL and testbench
==============================

Name: ctr_uart_tx

Overview:
- Downstream consumer for the fabric user-design counter stage.
- Accepts a NUM_IO-wide counter sample over a valid/ready handshake and serialises it on a single 8N1 UART line routed to one fabric IO pin.
- Lets the bring-up bench and the lab observe the counter value over a single pin instead of all 32 IOs.

Parameters:
- DATA_W, 32: sample width in bits; must be a multiple of 8 (and of 4 for hex mode). Defaults to the fabric NUM_IO.
- CLK_DIV, 4: clock cycles per UART bit; legal range 1..65535.

Ports:
- clk  input  1  fabric user clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- sample_data  input  DATA_W  counter value to send.
- sample_valid  input  1  sample_data is valid.
- sample_ready  output  1  block can accept a sample.
- tx  output  1  UART line, idle high.
- busy  output  1  a frame sequence is in progress.

Behaviour:
- Reset:
  - Asserting rst forces state IDLE, tx=1, busy=0 and divider/bit/byte counters to 0, immediately and regardless of clk.
  - sample_ready=1 in IDLE, including while rst is held.
  - Reset mid-frame aborts the frame; tx returns high at once, and there is no partial stop bit.
- Handshake:
  - Transfer happens on a rising edge with sample_valid=1 and sample_ready=1.
  - sample_data is captured into a shadow register on that edge; later changes to sample_data are ignored until the next transfer.
  - sample_ready = (state==IDLE), driven combinationally from the state register.
  - If sample_valid is high in IDLE, acceptance happens on the first edge; no valid-to-ready dependency.
- FSM states:
  - IDLE → START on transfer.
  - START → DATA after CLK_DIV cycles.
  - DATA → STOP after 8 bits of CLK_DIV cycles each.
  - STOP → START if more characters remain, else → IDLE after CLK_DIV cycles.
- Timing:
  - The start bit (tx=0) is driven from the cycle after the transfer edge.
  - Each bit is held exactly CLK_DIV cycles.
  - There is no idle gap between characters.
  - sample_ready re-asserts on the cycle after the last stop bit completes.
- Bit order: data bits are sent LSB first; the stop bit is 1.
- Character order (raw mode): DATA_W/8 bytes, most-significant byte first.
- Busy: busy=1 in every state except IDLE, and is registered alongside state.
- Total sequence length: N characters × 10 bits × CLK_DIV cycles.
- Counters:
  - The divider is a down-counter reloaded with CLK_DIV-1 on every bit boundary.
  - The bit counter is 3 bits.
  - The character index counter width is clog2(max characters + 1).
- Boundaries:
  - CLK_DIV=1 gives one cycle per bit, back-to-back.
  - A transfer attempted while busy is not accepted; ready is low, so no data is lost or corrupted.
  - All-zero and all-one samples transmit normally.

Optional Feature:
- Macro: CTR_UART_TX_HEX_EN.
- Defined:
  - Each sample is sent as DATA_W/4 ASCII uppercase hex digits, most-significant nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), followed by 0x0D and 0x0A.
  - That is DATA_W/4 + 2 characters per sample; the nibble-to-ASCII conversion is combinational from the shadow register.
- Undefined: raw binary mode as above; no hex logic is synthesised.
- FSM, timing and handshake are identical in both modes.

Test Plan:
- Raw basic: CLK_DIV=4, DATA_W=32. Send 0x12345678 → tx carries bytes 0x12, 0x34, 0x56, 0x78, each framed 0,LSB..MSB,1. busy high exactly 160 cycles. Start bit begins on the cycle after transfer.
- Back-to-back: sample_valid held high with 0x000000FF then 0xFFFFFF00 → second transfer occurs on the cycle after the 160th busy cycle. No tx glitch between the sequences (stop bit 1 leads directly into start bit 0).
- Ignore while busy: change sample_data to 0xDEADBEEF mid-frame with valid high → the first frame still sends the captured value, and sample_ready stays 0 until the frame ends.
- Async reset mid-frame: assert rst during the DATA state of byte 2 → tx=1, busy=0 and sample_ready=1 without a clock edge. After release, 0xA5A5A5A5 sends cleanly.
- CLK_DIV=1 edge: send 0x80000001 → each bit lasts 1 cycle, busy for 40 cycles, and the bit pattern matches exactly.
- Hex mode (CTR_UART_TX_HEX_EN, CLK_DIV=4): send 0x00AB00FF → characters "00AB00FF" then 0x0D, 0x0A; 10 characters; busy 400 cycles.

Source files
------------

// File: rtl/ctr_uart_tx.sv
// Serialises a DATA_W-bit counter sample onto one 8N1 UART line, most-significant byte first.
// Define CTR_UART_TX_HEX_EN to send uppercase ASCII hex digits plus CR/LF instead of raw bytes.
module ctr_uart_tx #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              tx,
  output logic              busy
);

  // Handshake: a sample transfers on a rising edge where sample_valid && sample_ready;
  // sample_ready depends only on the state register, never on sample_valid.

`ifdef CTR_UART_TX_HEX_EN
  localparam int NDIG  = DATA_W / 4;
  localparam int NCHAR = NDIG + 2;
`else
  localparam int NCHAR = DATA_W / 8;
`endif
  localparam int CW = $clog2(NCHAR + 1);
  localparam logic [15:0]   DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NCHAR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [15:0]       div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [CW-1:0]     char_q, char_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        cur_char;

  // Character currently on the wire, selected from the shadow register.
`ifdef CTR_UART_TX_HEX_EN
  logic [3:0] nib;
  always_comb begin
    shifted  = shadow_q << {char_q, 2'b00};
    nib      = shifted[DATA_W-1 -: 4];
    cur_char = 8'h0A;
    if (char_q < CW'(NDIG)) begin
      if (nib < 4'd10) cur_char = 8'h30 + {4'h0, nib};
      else             cur_char = 8'h37 + {4'h0, nib};
    end else if (char_q == CW'(NDIG)) begin
      cur_char = 8'h0D;
    end
  end
`else
  always_comb begin
    shifted  = shadow_q << {char_q, 3'b000};
    cur_char = shifted[DATA_W-1 -: 8];
  end
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    bit_d    = bit_q;
    char_d   = char_q;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          shadow_d = sample_data;
          state_d  = START;
          div_d    = DIV_LAST;
          bit_d    = 3'd0;
          char_d   = '0;
        end
      end
      START: begin
        if (div_q == 16'd0) begin
          state_d = DATA;
          div_d   = DIV_LAST;
          bit_d   = 3'd0;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      DATA: begin
        if (div_q == 16'd0) begin
          div_d = DIV_LAST;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      STOP: begin
        if (div_q == 16'd0) begin
          div_d = DIV_LAST;
          if (char_q == CHAR_LAST) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            char_d  = char_q + CW'(1);
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      div_q    <= 16'd0;
      bit_q    <= 3'd0;
      char_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      busy_q   <= busy_d;
    end
  end

  // tx decodes straight from registers so reset forces the line high without a clock.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = cur_char[bit_q];
      default: tx = 1'b1;
    endcase
  end

  assign sample_ready = (state_q == IDLE);
  assign busy         = busy_q;

endmodule

// File: tb/tb_ctr_uart_tx.sv
// Directed bench for ctr_uart_tx: one instance at CLK_DIV=4, one at CLK_DIV=1.
// Frames are checked bit-for-bit per character, with busy length and ready behaviour.
module tb_ctr_uart_tx;

`ifdef CTR_UART_TX_HEX_EN
  localparam int NCH = 10;
`else
  localparam int NCH = 4;
`endif
  localparam int CYC4 = NCH * 40;
  localparam int CYC1 = NCH * 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] data0 = '0, data1 = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        ready0, ready1, tx0, tx1, busy0, busy1;

  ctr_uart_tx #(.DATA_W(32), .CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .sample_data(data0), .sample_valid(valid0),
    .sample_ready(ready0), .tx(tx0), .busy(busy0)
  );

  ctr_uart_tx #(.DATA_W(32), .CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .sample_data(data1), .sample_valid(valid1),
    .sample_ready(ready1), .tx(tx1), .busy(busy1)
  );

  int   total = 0;
  int   bad   = 0;
  int   sel   = 0;
  logic tx_s, busy_s, ready_s;

  always_comb begin
    tx_s    = (sel == 1) ? tx1    : tx0;
    busy_s  = (sel == 1) ? busy1  : busy0;
    ready_s = (sel == 1) ? ready1 : ready0;
  end

  typedef struct {
    int          s;
    logic [31:0] d;
    int          cyc;
  } vec_t;
  vec_t vecs[6];

  string hexdig = "0123456789ABCDEF";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [31:0] d);
    if (s == 1) begin valid1 = v; data1 = d; end
    else        begin valid0 = v; data0 = d; end
  endtask

  function automatic logic [7:0] exp_char(input logic [31:0] d, input int idx);
    logic [31:0] t;
`ifdef CTR_UART_TX_HEX_EN
    if (idx < 8) begin
      t = d >> (4 * (7 - idx));
      return hexdig[t[3:0]];
    end
    return (idx == 8) ? 8'h0D : 8'h0A;
`else
    t = d >> (8 * (3 - idx));
    return t[7:0];
`endif
  endfunction

  // Starts at the first negedge after the transfer edge and walks every cycle of the sequence.
  task automatic check_frames(input string name, input logic [31:0] d, input int div, input int cyc);
    int       busy_cnt;
    int       ready_cnt;
    logic [9:0] fr;
    logic     gl;
    busy_cnt  = 0;
    ready_cnt = 0;
    for (int c = 0; c < NCH; c++) begin
      fr = '0;
      gl = 1'b0;
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < div; k++) begin
          @(negedge clk);
          if (busy_s)  busy_cnt++;
          if (ready_s) ready_cnt++;
          if (k == 0) fr[b] = tx_s;
          else if (tx_s !== fr[b]) gl = 1'b1;
        end
      end
      check($sformatf("%s_char%0d", name, c), {53'd0, gl, fr}, {53'd0, 1'b0, 1'b1, exp_char(d, c), 1'b0});
    end
    check($sformatf("%s_busy_len", name), 64'(busy_cnt), 64'(cyc));
    check($sformatf("%s_ready_low", name), 64'(ready_cnt), 64'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, {61'd0, busy_s, ready_s, tx_s}, 64'b011);
  endtask

  task automatic send(input int s, input logic [31:0] d, input int cyc, input string name);
    sel = s;
    @(negedge clk);
    check({name, "_ready"}, {63'd0, ready_s}, 64'd1);
    drive(s, 1'b1, d);
    @(posedge clk);
    #1 drive(s, 1'b0, d);
    check_frames(name, d, (s == 1) ? 1 : 4, cyc);
    check_idle({name, "_idle"});
  endtask

  initial begin
    vecs[0] = '{0, 32'h12345678, CYC4};
    vecs[1] = '{0, 32'h00000000, CYC4};
    vecs[2] = '{0, 32'hFFFFFFFF, CYC4};
    vecs[3] = '{1, 32'h80000001, CYC1};
    vecs[4] = '{0, 32'h00AB00FF, CYC4};
    vecs[5] = '{1, 32'h5A5A0F0F, CYC1};

    // Reset state before any clock edge.
    #2;
    check("rst_div4", {61'd0, busy0, ready0, tx0}, 64'b011);
    check("rst_div1", {61'd0, busy1, ready1, tx1}, 64'b011);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("post_rst_idle");

    for (int i = 0; i < 6; i++)
      send(vecs[i].s, vecs[i].d, vecs[i].cyc, $sformatf("vec%0d", i));

    // Back-to-back with valid held: one idle cycle, then the next start bit.
    sel = 0;
    @(negedge clk);
    drive(0, 1'b1, 32'h000000FF);
    @(posedge clk);
    #1 drive(0, 1'b1, 32'hFFFFFF00);
    check_frames("b2b_first", 32'h000000FF, 4, CYC4);
    check_idle("b2b_gap");
    @(posedge clk);
    #1 drive(0, 1'b0, 32'h0);
    check_frames("b2b_second", 32'hFFFFFF00, 4, CYC4);
    check_idle("b2b_idle");

    // Data changed while busy must not disturb the captured sample.
    @(negedge clk);
    drive(0, 1'b1, 32'h12345678);
    @(posedge clk);
    #1 drive(0, 1'b1, 32'hDEADBEEF);
    check_frames("ignore_busy", 32'h12345678, 4, CYC4);
    check_idle("ignore_idle");
    drive(0, 1'b0, 32'hDEADBEEF);
    check_idle("ignore_no_restart");

    // Asynchronous reset in the DATA state of the second byte.
    @(negedge clk);
    drive(0, 1'b1, 32'h12345678);
    @(posedge clk);
    #1 drive(0, 1'b0, 32'h0);
    repeat (46) @(negedge clk);
    check("pre_reset_busy", {62'd0, busy0, ready0}, 64'b10);
    #2 rst = 1'b1;
    #1 check("async_reset", {61'd0, busy0, ready0, tx0}, 64'b011);
    @(negedge clk);
    rst = 1'b0;
    send(0, 32'hA5A5A5A5, CYC4, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
